// File: rtl/fetch_stage_pkg.sv
// Purpose: shared types for the fetch stage and its consumers (decode, hazard detection).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: instruction_s, fd_s (F/D register), fetch_state_e, kNOP, default widths.
package fetch_stage_pkg;

  localparam int FETCH_ADDR_W  = 10;
  localparam int FETCH_INSTR_W = 16;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [11:0] operand;
  } instruction_s;

  typedef struct packed {
    instruction_s            instruction_fd;
    logic [FETCH_ADDR_W-1:0] pc_plus1_fd;
    logic                    valid_fd;
  } fd_s;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Non-zero NOP encoding so a squashed slot is distinguishable from word 0.
  localparam instruction_s kNOP = '{opcode: 4'hF, operand: 12'h000};

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// Purpose: next-PC priority mux (pc_next_sel) driving the sync instruction-memory address.
// Latency: combinational.
// Backpressure: bubble holds the current PC so the same word is re-read.
// Ports: state, jump_now, jump_pc, bubble, pc (current pc_r) in; next_pc out.
module fetch_stage_pc_next_sel
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  fetch_state_e      state,
  input  logic              jump_now,
  input  logic [ADDR_W-1:0] jump_pc,
  input  logic              bubble,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc
);

  always_comb begin
    next_pc = pc + 1'b1;  // free-running fetch, wraps naturally
    if (state == IDLE) begin
      next_pc = RESET_PC;
    end else if (jump_now) begin
      // A redirect wins over a stall and is also honoured while halted,
      // so the target is what gets fetched on resume.
      next_pc = jump_pc;
    end else if (state == HALT || bubble) begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Purpose: instruction fetch with F/D pipeline register, PC ownership and run/halt FSM.
// Latency: 1 cycle from address presentation to F/D capture (sync-read imem).
// Backpressure: bubble_i freezes PC and F/D; jump_now_i squashes F/D for one cycle.
// Ports: clk, reset (async high); start_i/halt_i control; bubble_i, jump_now_i/jump_pc_i
//        from hazard/execute; imem_addr_o/imem_data_i memory; fd_s_o, state_o, fetch_count_o out.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                     IMEM_ADDR_W = FETCH_ADDR_W,
  parameter int                     INSTR_W     = FETCH_INSTR_W,
  parameter logic [IMEM_ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   halt_i,
  input  logic                   bubble_i,
  input  logic                   jump_now_i,
  input  logic [IMEM_ADDR_W-1:0] jump_pc_i,
  output logic [IMEM_ADDR_W-1:0] imem_addr_o,
  input  logic [INSTR_W-1:0]     imem_data_i,
  output fd_s                    fd_s_o,
  output fetch_state_e           state_o,
  output logic [31:0]            fetch_count_o
);

  // pc_r is the address whose word is on imem_data_i this cycle.
  logic [IMEM_ADDR_W-1:0] pc_r;
  logic [IMEM_ADDR_W-1:0] next_pc;
  fetch_state_e           state_r;
  fd_s                    fd_r;
  logic [31:0]            count_r;

  fetch_stage_pc_next_sel #(
    .ADDR_W   (IMEM_ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_next_sel (
    .state    (state_r),
    .jump_now (jump_now_i),
    .jump_pc  (jump_pc_i),
    .bubble   (bubble_i),
    .pc       (pc_r),
    .next_pc  (next_pc)
  );

  assign imem_addr_o   = next_pc;
  assign fd_s_o        = fd_r;
  assign state_o       = state_r;
  assign fetch_count_o = count_r;

  // Run/halt control. halt_i has precedence over start_i in every state
  // that reacts to start_i.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:    if (start_i) state_r <= halt_i ? HALT : RUN;
        RUN:     if (halt_i) state_r <= HALT;
        HALT:    if (start_i && !halt_i) state_r <= RUN;
        default: state_r <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= next_pc;
    end
  end

  // F/D register and delivered-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fd_r    <= '{instruction_fd: kNOP, pc_plus1_fd: '0, valid_fd: 1'b0};
      count_r <= '0;
    end else if (state_r == RUN) begin
      if (jump_now_i) begin
        // Word on imem_data_i is on the wrong path: squash it.
        fd_r.valid_fd       <= 1'b0;
        fd_r.instruction_fd <= kNOP;
      end else if (!bubble_i) begin
        fd_r.instruction_fd <= instruction_s'(imem_data_i);
        fd_r.pc_plus1_fd    <= pc_r + 1'b1;
        fd_r.valid_fd       <= 1'b1;
        count_r             <= count_r + 32'd1;
      end
    end else begin
      // IDLE/HALT drain the pipeline register.
      fd_r.valid_fd       <= 1'b0;
      fd_r.instruction_fd <= kNOP;
    end
  end

endmodule
